// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared ARM32 register-file constants and bypass hit helper
package reg_file_pkg;
  localparam int REG_N = 16;
  localparam int REG_W = 32;
  localparam int REG_LR = 14;
  localparam int REG_PC = 15;
  localparam int PC_OFFSET = 8;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  function automatic logic hit(input logic we, input logic [3:0] ws, input logic [3:0] rs);
    return we && ws == rs;
  endfunction
endpackage

// File: rtl/reg_file_read_port.sv
// rf_read_port: one read mux with r15 substitution and two-level write bypass
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_OFF = PC_OFFSET,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              we1,
  input  logic [ADDR_W-1:0] ws1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] ws2,
  input  logic [DATA_W-1:0] wd2,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] rd
);
  logic hit1, hit2;
  assign hit1 = BYPASS && hit(we1, 4'(ws1), 4'(rs));
  assign hit2 = BYPASS && hit(we2, 4'(ws2), 4'(rs));
  // r15 takes priority over any in-flight write so a PC read is never forwarded
  assign rd = rs == ADDR_W'(REG_PC) ? pc_in + DATA_W'(PC_OFF) :
              hit1 ? wd1 : hit2 ? wd2 : stored;
endmodule

// File: rtl/reg_file.sv
// reg_file: 16x32 ARM32 register file, three combinational reads, two writes,
// r15 writes turned into a registered one-cycle redirect pulse
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = 4,
  parameter int PC_OFF = PC_OFFSET,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] rf_rs1,
  input  logic [ADDR_W-1:0] rf_rs2,
  input  logic [ADDR_W-1:0] rf_rs3,
  output logic [DATA_W-1:0] rf_rd1,
  output logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] rf_rd3,
  input  logic [ADDR_W-1:0] rf_ws1,
  input  logic [DATA_W-1:0] rf_wd1,
  input  logic              rf_we1,
  input  logic [ADDR_W-1:0] rf_ws2,
  input  logic [DATA_W-1:0] rf_wd2,
  input  logic              rf_we2,
  output logic              pc_wr_valid,
  output logic [DATA_W-1:0] pc_wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam logic [ADDR_W-1:0] PC = ADDR_W'(REG_PC);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic pc1, pc2;
  logic [ADDR_W-1:0] rs [3];
  logic [DATA_W-1:0] rd [3];
  assign pc1 = rf_we1 && rf_ws1 == PC;
  assign pc2 = rf_we2 && rf_ws2 == PC;
  // port 1 is applied last so it wins a same-register collision
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      pc_wr_valid <= FALSE;
      pc_wr_data <= '0;
    end else begin
      if (rf_we2 && !pc2) regs[rf_ws2] <= rf_wd2;
      if (rf_we1 && !pc1) regs[rf_ws1] <= rf_wd1;
      pc_wr_valid <= pc1 || pc2;
      if (pc1 || pc2) pc_wr_data <= pc1 ? rf_wd1 : rf_wd2;
    end
  assign rs[0] = rf_rs1;
  assign rs[1] = rf_rs2;
  assign rs[2] = rf_rs3;
  for (genvar g = 0; g < 3; g++) begin : g_rd
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_OFF(PC_OFF), .BYPASS(BYPASS)) u_rp (
      .rs(rs[g]), .pc_in(pc_in),
      .we1(rf_we1), .ws1(rf_ws1), .wd1(rf_wd1),
      .we2(rf_we2), .ws2(rf_ws2), .wd2(rf_wd2),
      .stored(regs[rs[g]]), .rd(rd[g])
    );
  end
  assign rf_rd1 = rd[0];
  assign rf_rd2 = rd[1];
  assign rf_rd3 = rd[2];
  assign dbg_data = dbg_addr == PC ? pc_in : regs[dbg_addr];
endmodule
